// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
// Request/result bundle between the execute-stage controller and the
// iterative multiply/divide unit.
//   master: controller side, drives start/op/a/b and the MTHI/MTLO strobes,
//           observes busy/done/hi/lo
//   slave : mul_div_unit side
// Ports carried:
//   start, op[1:0], a, b         operation request and operands
//   wr_hi, wr_lo, wr_data        MTHI/MTLO writes
//   busy, done, hi, lo           status and architectural HI/LO
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative MIPS32 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both take
// WIDTH CALC cycles plus one FIX cycle, so done rises WIDTH+2 cycles after
// start regardless of operands.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mul_div_unit_if.slave (start/op/a/b, wr_hi/wr_lo/wr_data,
//          busy/done/hi/lo)
// Configuration:
//   MDU_DIV_EN  when defined the divider datapath is built; otherwise
//               DIV/DIVU keep the same timing but write hi=0, lo=0.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_res;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  // Operand conditioning at capture time: signed ops work on magnitudes
  // and remember the signs for the FIX cycle.
  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign is_signed = ~bus.op[0];
  assign sign_a    = is_signed & bus.a[WIDTH-1];
  assign sign_b    = is_signed & bus.b[WIDTH-1];
  assign abs_a     = sign_a ? -bus.a : bus.a;
  assign abs_b     = sign_b ? -bus.b : bus.b;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  // The carry out of the add lands in the top bit after the right shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] product;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign product = neg_res ? -acc : acc;

`ifdef MDU_DIV_EN
  // Restoring divide: acc[WIDTH-1:0] starts as the dividend and fills with
  // quotient bits from the right; the shifted partial remainder is WIDTH+1
  // bits wide for the trial subtract, the stored remainder fits in WIDTH.
  logic             neg_rem;
  logic             div_zero;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;

  assign div_shift    = {rem, acc[WIDTH-1]};
  assign div_ge       = div_shift >= {1'b0, opnd};
  assign div_rem_next = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
`endif

  // Result selection for the FIX write-back.
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    fix_hi = product[2*WIDTH-1:WIDTH];
    fix_lo = product[WIDTH-1:0];
    if (is_div) begin
`ifdef MDU_DIV_EN
      // Divide by zero leaves the remainder equal to |a|, so restoring its
      // sign reproduces the original dividend; the quotient is forced to
      // all-ones instead of being sign-corrected.
      fix_hi = neg_rem ? -rem : rem;
      fix_lo = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
`else
      fix_hi = '0;
      fix_lo = '0;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; CALC runs exactly WIDTH cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = CALC;
      CALC: if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and HI/LO registers. In IDLE a start takes priority over the
  // MTHI/MTLO strobes, which are dropped in that case.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rem      <= '0;
`endif
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.start) begin
            count   <= '0;
            is_div  <= bus.op[1];
            neg_res <= sign_a ^ sign_b;
            opnd    <= bus.op[1] ? abs_b : abs_a;
            acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
`ifdef MDU_DIV_EN
            neg_rem  <= sign_a;
            div_zero <= (bus.b == '0);
            rem      <= '0;
`endif
          end else begin
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
          end
        end
        CALC: begin
          count <= count + 1'b1;
`ifdef MDU_DIV_EN
          if (is_div) begin
            rem             <= div_rem_next;
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
`else
          acc <= {mul_sum, acc[WIDTH-1:1]};
`endif
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit: each accepted operation pushes its
// expected HI/LO (from a behavioural model using native arithmetic) and the
// entry is popped and compared when done is seen. Also covers reset,
// busy/done timing, ignored requests while busy, MTHI/MTLO and abort.
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          test_count = 0;
  int          fail_count = 0;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: {hi, lo} for one operation.
  function automatic logic [63:0] modelResult(input logic [1:0] op_i,
                                              input logic [31:0] a_i,
                                              input logic [31:0] b_i);
    longint      sp;
    logic [63:0] up;
    int          ia, ib, iq, ir;
    logic [31:0] uq, ur;
    case (op_i)
      2'b00: begin
        sp = longint'($signed(a_i)) * longint'($signed(b_i));
        return 64'(sp);
      end
      2'b01: begin
        up = {32'b0, a_i} * {32'b0, b_i};
        return up;
      end
      default: begin
`ifdef MDU_DIV_EN
        if (b_i == 32'h0) return {a_i, 32'hFFFF_FFFF};
        if (op_i == 2'b10) begin
          if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
          ia = a_i;
          ib = b_i;
          iq = ia / ib;
          ir = ia % ib;
          return {32'(ir), 32'(iq)};
        end
        uq = a_i / b_i;
        ur = a_i % b_i;
        return {ur, uq};
`else
        ia = 0; ib = 0; iq = 0; ir = 0; uq = '0; ur = '0;
        return 64'h0;
`endif
      end
    endcase
  endfunction

  // Drive a start request for the current cycle and record its expectation.
  task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a_i,
                               input logic [31:0] b_i);
    logic [63:0] r;
    exp_t        e;
    r    = modelResult(op_i, a_i, b_i);
    e.hi = r[63:32];
    e.lo = r[31:0];
    sb.push_back(e);
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    bus.start = 1'b1;
  endtask

  // Run one operation from cycle 0 to its done cycle. poke_cycle>0 fires an
  // ignored start + wr_hi in that cycle; with_wr_lo raises wr_lo with start.
  task automatic runOp(input logic [1:0] op_i, input logic [31:0] a_i,
                       input logic [31:0] b_i, input int poke_cycle,
                       input bit with_wr_lo);
    int   cyc;
    exp_t e;
    applyStimulus(op_i, a_i, b_i);
    if (with_wr_lo) begin
      bus.wr_lo   = 1'b1;
      bus.wr_data = 32'h1111_1111;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.wr_lo = 1'b0;
    cyc = 1;
    checkOutput("busy_c1", 64'(bus.busy), 64'd1);
    checkOutput("done_c1", 64'(bus.done), 64'd0);
    checkOutput("lo_hold_c1", 64'(bus.lo), 64'(model_lo));
    checkOutput("hi_hold_c1", 64'(bus.hi), 64'(model_hi));
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == poke_cycle) begin
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.a       = 32'd1;
        bus.b       = 32'd1;
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h0000_1234;
      end
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      bus.wr_hi = 1'b0;
      if (cyc == poke_cycle + 1)
        checkOutput("hi_hold_busy", 64'(bus.hi), 64'(model_hi));
      if (cyc == 33) begin
        checkOutput("busy_c33", 64'(bus.busy), 64'd1);
        checkOutput("done_c33", 64'(bus.done), 64'd0);
      end
    end
    checkOutput("latency", 64'(cyc), 64'd34);
    checkOutput("busy_done", 64'(bus.busy), 64'd0);
    e = sb.pop_front();
    checkOutput("hi", 64'(bus.hi), 64'(e.hi));
    checkOutput("lo", 64'(bus.lo), 64'(e.lo));
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t directed[$] = '{
    '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007},
    '{2'b00, 32'h8000_0000, 32'h8000_0000},
    '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002},
    '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF},
    '{2'b11, 32'h0000_0064, 32'h0000_0000},
    '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000},
    '{2'b11, 32'hDEAD_BEEF, 32'h0000_1234}
  };

  initial begin
    int done_pulses;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hi", 64'(bus.hi), 64'd0);
    checkOutput("rst_lo", 64'(bus.lo), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    rst_n    = 1'b1;
    model_hi = '0;
    model_lo = '0;

    // Widest unsigned product, then a busy-time start + wr_hi that must be
    // ignored while hi still holds that nonzero result.
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    runOp(2'b01, 32'd5, 32'd6, 5, 1'b0);

    // Abort in cycle 10: registers cleared and no done pulse afterwards.
    bus.op    = 2'b01;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("abort_hi", 64'(bus.hi), 64'd0);
    checkOutput("abort_lo", 64'(bus.lo), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    done_pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) done_pulses++;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_done", 64'(done_pulses), 64'd0);
    model_hi = '0;
    model_lo = '0;

    // Directed signed/unsigned cases, back to back.
    foreach (directed[i]) runOp(directed[i].op, directed[i].a, directed[i].b, 0, 1'b0);

    // MTHI and MTLO together in IDLE.
    bus.wr_hi   = 1'b1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    checkOutput("mt_hi", 64'(bus.hi), 64'hCAFE_F00D);
    checkOutput("mt_lo", 64'(bus.lo), 64'hCAFE_F00D);
    checkOutput("mt_done", 64'(bus.done), 64'd0);
    model_hi = 32'hCAFE_F00D;
    model_lo = 32'hCAFE_F00D;

    // start wins over a simultaneous wr_lo.
    runOp(2'b01, 32'd2, 32'd3, 0, 1'b1);

    // Random mix, some divisors zero or small.
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      runOp(rop, ra, rb, 0, 1'b0);
    end

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS32 datapath. It sits beside the ALU in the execute stage and takes the same register-file operands `a`/`b`. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the results in architectural HI/LO registers. HI/LO feed the writeback mux for MFHI/MFLO, and the controller stalls on `busy`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration counter is `$clog2(WIDTH)+1` bits.

- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request an operation; sampled only in IDLE.
- `op` input 2: operation select.
  - 00 MULT (signed)
  - 01 MULTU
  - 10 DIV (signed)
  - 11 DIVU
- `a` input WIDTH: multiplicand or dividend.
- `b` input WIDTH: multiplier or divisor.
- `wr_hi` input 1: MTHI write strobe.
- `wr_lo` input 1: MTLO write strobe.
- `wr_data` input WIDTH: data for MTHI/MTLO.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle pulse when HI/LO have been updated by an operation.
- `hi` output WIDTH: HI register (product high word, or remainder).
- `lo` output WIDTH: LO register (product low word, or quotient).

## Operation
- States:
  - IDLE: accepts `start`, `wr_hi`, `wr_lo`.
  - CALC: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
- Operand capture in IDLE when `start` is high:
  - Latch `op`.
  - Signed ops: latch |a|, |b| and the sign flags.
  - Unsigned ops: latch the raw operands.
- Multiply, one step per CALC cycle:
  - Shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- Divide, one step per CALC cycle:
  - Restoring division, one quotient bit per cycle.
  - The partial remainder is WIDTH+1 bits.
- FIX, multiply: negate the 2·WIDTH product if the operand signs differ.
- FIX, divide:
  - Negate the quotient if the signs differ.
  - The remainder takes the sign of the dividend.
- FIX write-back:
  - Multiply: {hi,lo} ← product.
  - Divide: lo ← quotient, hi ← remainder.
- Divide by zero (b==0, DIV or DIVU):
  - hi = a (unmodified dividend), lo = all-ones.
  - Latency is the same as a normal divide.
- Signed overflow: 0x80000000 / −1 gives lo=0x80000000, hi=0, with no trap.
- `start` while busy: ignored; no queueing.
- `wr_hi`/`wr_lo` rules:
  - Applied in IDLE only; ignored while busy.
  - If `start` and a write arrive in the same IDLE cycle, `start` wins and the write is dropped.
  - `wr_hi` and `wr_lo` together are both applied.
- `done` is not asserted for MTHI/MTLO writes.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset mid-operation: the operation is aborted with no `done` pulse.
- Cycle numbering from a `start` sampled at the end of cycle 0:
  - Cycles 1..WIDTH (1..32): CALC.
  - Cycle 33: FIX.
  - Cycle 34: hi/lo hold the new result and `done`=1.
- Latency is WIDTH+2 cycles from `start` to `done`, independent of operand values.
- `busy` = (state≠IDLE): high in cycles 1..33, low in cycle 34.
- A new `start` is accepted in cycle 34 (back-to-back operations allowed).
- `hi`/`lo` are registered and change only at the FIX edge or on an IDLE write edge.

## Configuration
- `MDU_DIV_EN` defined:
  - Full divider datapath is present.
- `MDU_DIV_EN` undefined:
  - No divider logic is built.
  - DIV/DIVU are still accepted with the identical WIDTH+2 latency and `busy`/`done` behaviour.
  - FIX writes hi=0, lo=0.
  - Multiply is unaffected.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy high cycles 1–33; done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → hi=0x00000064, lo=0xFFFFFFFF, done in cycle 34. With `MDU_DIV_EN` undefined, the same op → hi=0, lo=0, done in cycle 34.
- Start MULTU 5×6, pulse `start` (op=DIVU, a=1, b=1) and `wr_hi` (wr_data=0x1234) in cycle 5 → both ignored; result hi=0, lo=30.
- Start MULTU 5×6, assert `rst_n`=0 in cycle 10 → hi=lo=0, busy=0, no done pulse.
- In IDLE, `wr_hi`=1 and `wr_lo`=1 with wr_data=0xCAFEF00D → both hi and lo =0xCAFEF00D next cycle, done stays 0.
- `start` together with `wr_lo` in IDLE → lo not written; operation proceeds.
